vending_customer: RTL and testbench

VENDING_CUSTOMER -- requirements
Module: vending_customer

---
 rtl/vending_customer.sv | 170 +++++++++++++++++
 tb/tb_vending_customer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_customer.sv
// vending_customer: drives a coin-operated vending machine on behalf of a
// customer. It inserts coins largest-first until the wanted item shows as
// available, selects it, then collects the change before reporting done.
module vending_customer #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int SELECT_TIMEOUT = 16,
  parameter int RET_IDLE       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [1:0]  i_item,
  input  logic [3:0]  i_wallet_100,
  input  logic [3:0]  i_wallet_500,
  input  logic [3:0]  i_wallet_1000,
  input  logic [3:0]  o_available_item,
  input  logic [3:0]  o_output_item,
  input  logic [2:0]  o_return_coin,
  output logic [2:0]  i_input_coin,
  output logic [3:0]  i_select_item,
  output logic        i_trigger_return,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fail,
  output logic [15:0] o_inserted,
  output logic [15:0] o_change
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] INSERT = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] SELECT = 3'd4;
  localparam logic [2:0] RETURN = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // One shared cycle counter serves the settle, select-timeout and
  // return-idle phases; they never overlap.
  localparam int CW = 16;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SELECT_LAST = CW'(SELECT_TIMEOUT - 1);
  localparam logic [CW-1:0] RET_LAST    = CW'(RET_IDLE - 1);

  logic [2:0]    state;
  logic [1:0]    item_q;
  logic [3:0]    w100_q;
  logic [3:0]    w500_q;
  logic [3:0]    w1000_q;
  logic [CW-1:0] cnt;
  logic [15:0]   ret_value;
  logic [3:0]    sel_onehot;

  // Value of the change coins presented this cycle; several denominations
  // may arrive together and are summed.
  always_comb begin
    ret_value = 16'd0;
    if (o_return_coin[0]) ret_value = ret_value + 16'd100;
    if (o_return_coin[1]) ret_value = ret_value + 16'd500;
    if (o_return_coin[2]) ret_value = ret_value + 16'd1000;
    sel_onehot = 4'b0001 << item_q;
  end

  // Purchase sequencer; every machine-facing output is a register so the
  // coin, select and return strobes can never glitch into one another.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      item_q           <= 2'd0;
      w100_q           <= 4'd0;
      w500_q           <= 4'd0;
      w1000_q          <= 4'd0;
      cnt              <= '0;
      i_input_coin     <= 3'b000;
      i_select_item    <= 4'b0000;
      i_trigger_return <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_fail           <= 1'b0;
      o_inserted       <= 16'd0;
      o_change         <= 16'd0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            item_q     <= i_item;
            w100_q     <= i_wallet_100;
            w500_q     <= i_wallet_500;
            w1000_q    <= i_wallet_1000;
            o_inserted <= 16'd0;
            o_change   <= 16'd0;
            o_fail     <= 1'b0;
            o_busy     <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (o_available_item[item_q]) begin
            i_select_item <= sel_onehot;
            cnt           <= '0;
            state         <= SELECT;
          end else if (w1000_q != 4'd0) begin
            i_input_coin <= 3'b100;
            w1000_q      <= w1000_q - 4'd1;
            o_inserted   <= o_inserted + 16'd1000;
            state        <= INSERT;
          end else if (w500_q != 4'd0) begin
            i_input_coin <= 3'b010;
            w500_q       <= w500_q - 4'd1;
            o_inserted   <= o_inserted + 16'd500;
            state        <= INSERT;
          end else if (w100_q != 4'd0) begin
            i_input_coin <= 3'b001;
            w100_q       <= w100_q - 4'd1;
            o_inserted   <= o_inserted + 16'd100;
            state        <= INSERT;
          end else begin
            o_fail           <= 1'b1;
            i_trigger_return <= 1'b1;
            cnt              <= '0;
            state            <= RETURN;
          end
        end
        INSERT: begin
          i_input_coin <= 3'b000;
          cnt          <= '0;
          state        <= SETTLE;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) state <= CHECK;
          else                    cnt   <= cnt + 1'b1;
        end
        SELECT: begin
          if (o_output_item[item_q]) begin
            i_select_item    <= 4'b0000;
            i_trigger_return <= 1'b1;
            cnt              <= '0;
            state            <= RETURN;
          end else if (cnt == SELECT_LAST) begin
            i_select_item    <= 4'b0000;
            i_trigger_return <= 1'b1;
            o_fail           <= 1'b1;
            cnt              <= '0;
            state            <= RETURN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RETURN: begin
          o_change <= o_change + ret_value;
          if (o_return_coin != 3'b000) begin
            cnt <= '0;
          end else if (cnt == RET_LAST) begin
            i_trigger_return <= 1'b0;
            o_done           <= 1'b1;
            state            <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_customer.sv
// tb_vending_customer: randomized purchases against a behavioural vending
// machine; a scoreboard queue holds the expected outcome of each accepted
// purchase and a monitor compares it when o_done pulses.
module tb_vending_customer;

  localparam int SETTLE_CYCLES  = 2;
  localparam int SELECT_TIMEOUT = 16;
  localparam int RET_IDLE       = 4;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [1:0]  i_item;
  logic [3:0]  i_wallet_100;
  logic [3:0]  i_wallet_500;
  logic [3:0]  i_wallet_1000;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic [2:0]  i_input_coin;
  logic [3:0]  i_select_item;
  logic        i_trigger_return;
  logic        o_busy;
  logic        o_done;
  logic        o_fail;
  logic [15:0] o_inserted;
  logic [15:0] o_change;

  vending_customer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SELECT_TIMEOUT(SELECT_TIMEOUT),
    .RET_IDLE      (RET_IDLE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_start         (i_start),
    .i_item          (i_item),
    .i_wallet_100    (i_wallet_100),
    .i_wallet_500    (i_wallet_500),
    .i_wallet_1000   (i_wallet_1000),
    .o_available_item(o_available_item),
    .o_output_item   (o_output_item),
    .o_return_coin   (o_return_coin),
    .i_input_coin    (i_input_coin),
    .i_select_item   (i_select_item),
    .i_trigger_return(i_trigger_return),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_fail          (o_fail),
    .o_inserted      (o_inserted),
    .o_change        (o_change)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int inserted;
    int change;
    int fail;
    int coins;
    int sel_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Machine configuration, written only by the stimulus process
  int   price[4];
  bit   no_dispense;
  int   lat;
  logic [1:0] cur_item;

  // Machine state
  logic [15:0] credit;
  logic [3:0]  out_q;
  logic [3:0]  noise_q;
  logic [2:0]  ret_q;
  logic [2:0]  ret_noise_q;
  logic [2:0]  ret_pick;
  int unsigned pick_rand;
  int          gap_cnt;
  int          lat_cnt;
  bit          dispensed;

  function automatic int coin_value(logic [2:0] c);
    return (c[0] ? 100 : 0) + (c[1] ? 500 : 0) + (c[2] ? 1000 : 0);
  endfunction

  function automatic logic [2:0] pick_return(int cr, int unsigned r);
    logic [2:0] b = 3'b000;
    int rem = cr;
    if (rem >= 1000) begin b[2] = 1'b1; rem -= 1000; end
    if (rem >= 500 && (b == 3'b000 || r[0])) begin b[1] = 1'b1; rem -= 500; end
    if (rem >= 100 && (b == 3'b000 || r[1])) b[0] = 1'b1;
    return b;
  endfunction

  // Reference outcome: spend largest coins first until the price is covered.
  function automatic exp_t model(int w100, int w500, int w1000, int p, bit nodisp);
    exp_t e;
    int cr = 0;
    e.coins = 0;
    e.sel_cycles = -1;
    while (cr < p && (w100 + w500 + w1000) > 0) begin
      if (w1000 > 0)     begin cr += 1000; w1000--; end
      else if (w500 > 0) begin cr += 500;  w500--;  end
      else               begin cr += 100;  w100--;  end
      e.coins++;
    end
    e.inserted = cr;
    if (cr >= p && !nodisp) begin
      e.fail   = 0;
      e.change = cr - p;
    end else begin
      e.fail   = 1;
      e.change = cr;
      if (cr >= p) e.sel_cycles = SELECT_TIMEOUT;
    end
    return e;
  endfunction

  // Availability follows the machine's credit against each item price
  always_comb begin
    for (int i = 0; i < 4; i++) o_available_item[i] = (int'(credit) >= price[i]);
    ret_pick      = pick_return(int'(credit), pick_rand);
    o_output_item = out_q | (noise_q & ~(4'b0001 << cur_item));
    o_return_coin = i_trigger_return ? ret_q : ret_noise_q;
  end

  // Machine: banks coins, dispenses after a latency, returns credit as change
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit      <= 16'd0;
      out_q       <= 4'd0;
      noise_q     <= 4'd0;
      ret_q       <= 3'd0;
      ret_noise_q <= 3'd0;
      pick_rand   <= 0;
      gap_cnt     <= 0;
      lat_cnt     <= 0;
      dispensed   <= 1'b0;
    end else begin
      noise_q     <= 4'($urandom);
      ret_noise_q <= 3'($urandom);
      pick_rand   <= $urandom;
      out_q       <= 4'd0;
      ret_q       <= 3'd0;
      if (i_input_coin != 3'b000) begin
        credit <= credit + 16'(coin_value(i_input_coin));
      end else if (i_select_item != 4'b0000) begin
        if (!no_dispense && !dispensed && i_select_item[cur_item] &&
            int'(credit) >= price[cur_item]) begin
          if (lat_cnt >= lat) begin
            out_q     <= 4'b0001 << cur_item;
            credit    <= credit - 16'(price[cur_item]);
            dispensed <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1;
          end
        end
      end else if (i_trigger_return && credit != 16'd0) begin
        if (gap_cnt > 0) begin
          gap_cnt <= gap_cnt - 1;
        end else begin
          ret_q   <= ret_pick;
          credit  <= credit - 16'(coin_value(ret_pick));
          gap_cnt <= $urandom_range(RET_IDLE - 2, 0);
        end
      end
      if (!i_trigger_return) gap_cnt <= 0;
      if (i_select_item == 4'b0000) begin
        lat_cnt   <= 0;
        dispensed <= 1'b0;
      end
    end
  end

  task automatic check_output(string name, int actual, int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: per-purchase protocol tracking and scoreboard comparison at o_done
  initial begin
    int   n_coins = 0;
    int   sel_cycles = 0;
    int   viol = 0;
    logic [2:0] coin_prev = 3'b000;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_coins = 0; sel_cycles = 0; viol = 0; coin_prev = 3'b000;
      end else begin
        if (i_input_coin != 3'b000) begin
          n_coins++;
          if ($countones(i_input_coin) != 1) viol++;
          if (coin_prev != 3'b000) viol++;
        end
        if (i_select_item != 4'b0000) begin
          sel_cycles++;
          if (i_select_item != (4'b0001 << cur_item)) viol++;
        end
        if (int'(i_input_coin != 3'b000) + int'(i_select_item != 4'b0000) +
            int'(i_trigger_return) > 1) viol++;
        coin_prev = i_input_coin;
        if (o_done) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_output("inserted", int'(o_inserted), e.inserted);
            check_output("change", int'(o_change), e.change);
            check_output("fail_flag", int'(o_fail), e.fail);
            check_output("coin_pulses", n_coins, e.coins);
            check_output("protocol_violations", viol, 0);
            if (e.sel_cycles >= 0) check_output("select_cycles", sel_cycles, e.sel_cycles);
          end
          n_coins = 0; sel_cycles = 0; viol = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (o_busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (o_busy) check_output("idle_wait", int'(o_busy), 0);
  endtask

  // Issue one purchase, push its expected outcome, then poke i_start while busy
  task automatic apply_stimulus(int item, int w100, int w500, int w1000, int p,
                                bit nodisp, bit junk);
    wait_idle();
    for (int i = 0; i < 4; i++) price[i] = 100 * $urandom_range(30, 0);
    price[item] = p;
    cur_item    = 2'(item);
    no_dispense = nodisp;
    lat         = $urandom_range(3, 0);
    exp_q.push_back(model(w100, w500, w1000, p, nodisp));
    i_item        = 2'(item);
    i_wallet_100  = 4'(w100);
    i_wallet_500  = 4'(w500);
    i_wallet_1000 = 4'(w1000);
    i_start       = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (junk) begin
      repeat ($urandom_range(4, 1)) @(negedge clk);
      if (o_busy) begin
        i_item        = 2'($urandom);
        i_wallet_100  = 4'($urandom);
        i_wallet_500  = 4'($urandom);
        i_wallet_1000 = 4'($urandom);
        i_start       = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
    end
  endtask

  // Main sequence: reset values, directed purchases, reset abort, random mix
  initial begin
    int guard;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_item = 2'd0;
    i_wallet_100 = 4'd0;
    i_wallet_500 = 4'd0;
    i_wallet_1000 = 4'd0;
    no_dispense = 1'b0;
    lat = 0;
    cur_item = 2'd0;
    for (int i = 0; i < 4; i++) price[i] = 0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", int'(o_busy), 0);
    check_output("reset_done", int'(o_done), 0);
    check_output("reset_coin", int'(i_input_coin), 0);
    check_output("reset_select", int'(i_select_item), 0);
    check_output("reset_trigger", int'(i_trigger_return), 0);
    check_output("reset_inserted", int'(o_inserted), 0);
    check_output("reset_change", int'(o_change), 0);
    reset_n = 1'b1;
    @(negedge clk);

    apply_stimulus(3, 0, 0, 3, 2000, 1'b0, 1'b1);
    apply_stimulus(0, 5, 0, 0, 400, 1'b0, 1'b0);
    apply_stimulus(2, 1, 1, 0, 1000, 1'b0, 1'b1);
    apply_stimulus(1, 2, 1, 1, 1500, 1'b1, 1'b0);
    apply_stimulus(0, 0, 0, 0, 300, 1'b0, 1'b0);
    apply_stimulus(1, 2, 2, 2, 0, 1'b0, 1'b0);

    // Abort a purchase while a coin pulse is on the wire
    apply_stimulus(2, 3, 3, 3, 3000, 1'b0, 1'b0);
    guard = 0;
    while (i_input_coin == 3'b000 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_output("coin_seen_before_abort", int'(i_input_coin != 3'b000), 1);
    reset_n = 1'b0;
    #1;
    check_output("abort_coin", int'(i_input_coin), 0);
    check_output("abort_busy", int'(o_busy), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("abort_no_done_busy", int'(o_busy), 0);

    for (int n = 0; n < 40; n++) begin
      apply_stimulus($urandom_range(3, 0), $urandom_range(4, 0), $urandom_range(4, 0),
                     $urandom_range(3, 0), 100 * $urandom_range(30, 0),
                     ($urandom_range(7, 0) == 0), $urandom_range(1, 0) == 1);
    end

    guard = 0;
    while ((exp_q.size() != 0 || o_busy) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
